// File: rtl/jtoutrun_subbus_req.sv
// Main-CPU side bus-request initiator for the sub-CPU window.
// Captures a cycle, raises sub_br, waits for sub_ok or a watchdog.
module jtoutrun_subbus_req #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [18:0] main_A,
  input  logic [1:0]  main_dsn,
  input  logic        main_rnw,
  input  logic [15:0] main_dout,
  input  logic        sub_ok,
  input  logic [15:0] sub_din,
  input  logic        clr_err,
  output logic        sub_br,
  output logic [18:0] req_A,
  output logic [1:0]  req_dsn,
  output logic        req_rnw,
  output logic [15:0] req_dout,
  output logic [15:0] main_din,
  output logic        main_ok,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt, cnt_nxt;
  logic          start, succ, tout;

  logic        br_nxt, ok_nxt, rnw_nxt, err_nxt;
  logic [18:0] a_nxt;
  logic [1:0]  dsn_nxt;
  logic [15:0] dout_nxt, din_nxt;

  assign start = cs && (main_dsn != 2'b11);
  // sub_ok is only trusted after sub_br has been up for SETTLE cycles
  assign succ  = (cnt >= CW'(SETTLE)) && sub_ok;
  assign tout  = (cnt == CW'(TIMEOUT - 1)) && !succ;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!cs)               state_nxt = ST_IDLE;
        else if (succ || tout) state_nxt = ST_HOLD;
      end
      ST_HOLD: if (!cs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    br_nxt   = sub_br;
    ok_nxt   = main_ok;
    din_nxt  = main_din;
    a_nxt    = req_A;
    dsn_nxt  = req_dsn;
    rnw_nxt  = req_rnw;
    dout_nxt = req_dout;
    cnt_nxt  = cnt;
    err_nxt  = timeout_err & ~clr_err;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          a_nxt    = main_A;
          dsn_nxt  = main_dsn;
          rnw_nxt  = main_rnw;
          dout_nxt = main_dout;
          br_nxt   = 1'b1;
          cnt_nxt  = '0;
        end else begin
          dsn_nxt  = 2'b11;
          rnw_nxt  = 1'b1;
          br_nxt   = 1'b0;
          ok_nxt   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt != CW'(TIMEOUT)) cnt_nxt = cnt + CW'(1);
        if (!cs) begin
          br_nxt  = 1'b0;
          dsn_nxt = 2'b11;
        end else if (succ) begin
          if (req_rnw) din_nxt = sub_din;
          ok_nxt  = 1'b1;
          br_nxt  = 1'b0;
          dsn_nxt = 2'b11;
        end else if (tout) begin
          din_nxt = 16'hffff;
          ok_nxt  = 1'b1;
          err_nxt = 1'b1;
          br_nxt  = 1'b0;
          dsn_nxt = 2'b11;
        end
      end
      ST_HOLD: if (!cs) ok_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_br      <= 1'b0;
      main_ok     <= 1'b0;
      main_din    <= '0;
      req_A       <= '0;
      req_dsn     <= 2'b11;
      req_rnw     <= 1'b1;
      req_dout    <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      sub_br      <= br_nxt;
      main_ok     <= ok_nxt;
      main_din    <= din_nxt;
      req_A       <= a_nxt;
      req_dsn     <= dsn_nxt;
      req_rnw     <= rnw_nxt;
      req_dout    <= dout_nxt;
      timeout_err <= err_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_jtoutrun_subbus_req.sv
// Bench for jtoutrun_subbus_req: scenario tasks with a
// scoreboard of expected completions (data, latency, error).
module tb_jtoutrun_subbus_req;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1024;
  localparam int CW      = 11;
  localparam int IMM     = SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [18:0] main_A;
  logic [1:0]  main_dsn;
  logic        main_rnw;
  logic [15:0] main_dout;
  logic        sub_ok;
  logic [15:0] sub_din;
  logic        clr_err;
  logic        sub_br;
  logic [18:0] req_A;
  logic [1:0]  req_dsn;
  logic        req_rnw;
  logic [15:0] req_dout;
  logic [15:0] main_din;
  logic        main_ok;
  logic        timeout_err;

  always #5 clk = ~clk;

  jtoutrun_subbus_req #(
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .main_A(main_A), .main_dsn(main_dsn),
    .main_rnw(main_rnw), .main_dout(main_dout),
    .sub_ok(sub_ok), .sub_din(sub_din),
    .clr_err(clr_err), .sub_br(sub_br),
    .req_A(req_A), .req_dsn(req_dsn),
    .req_rnw(req_rnw), .req_dout(req_dout),
    .main_din(main_din), .main_ok(main_ok),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] din;
    int          lat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [56:0] RST_VEC =
    {1'b0, 1'b0, 16'h0, 19'h0, 2'b11, 1'b1, 16'h0, 1'b0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cs = 0; main_A = '0; main_dsn = 2'b11;
    main_rnw = 1; main_dout = '0;
    sub_ok = 0; sub_din = '0; clr_err = 0;
  endtask

  task automatic start(input logic [18:0] a, input logic [1:0] dsn,
                       input logic rnw, input logic [15:0] d);
    cs = 1; main_A = a; main_dsn = dsn;
    main_rnw = rnw; main_dout = d;
  endtask

  task automatic wait_ok(input int budget, output int n, output bit got);
    got = 0;
    n = 0;
    while (!got && n < budget) begin
      tick;
      n++;
      if (main_ok === 1'b1) got = 1;
    end
  endtask

  task automatic finish_txn;
    cs = 0;
    sub_ok = 0;
    tick;
  endtask

  function automatic logic [56:0] out_vec();
    return {sub_br, main_ok, main_din, req_A, req_dsn,
            req_rnw, req_dout, timeout_err};
  endfunction

  task automatic test_reset;
    int n; bit got; exp_t e;
    idle_inputs;
    rst = 1;
    tick; tick;
    tests_run++;
    if (out_vec() !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_vals: got %h want %h", out_vec(), RST_VEC);
    end
    start(19'h12345, 2'b00, 1'b1, 16'h0);
    tick;
    tests_run++;
    if (sub_br !== 1'b0) begin
      tests_failed++;
      $display("FAIL br_in_rst: got %b want 0", sub_br);
    end
    rst = 0;
    tick;
    tests_run++;
    if (sub_br !== 1'b1 || req_A !== 19'h12345) begin
      tests_failed++;
      $display("FAIL cs_at_release: br %b A %h want 1 12345", sub_br, req_A);
    end
    sub_ok = 1; sub_din = 16'h5a5a;
    sb.push_back('{din: 16'h5a5a, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat || main_din !== e.din || timeout_err !== e.err) begin
      tests_failed++;
      $display("FAIL release_txn: got ok %0d lat %0d din %h want lat %0d din %h",
               got, n, main_din, e.lat, e.din);
    end
    finish_txn;
  endtask

  task automatic test_read;
    int n; bit got; exp_t e;
    tick;
    start(19'h60000, 2'b00, 1'b1, 16'h0);
    tick;
    tests_run++;
    if (sub_br !== 1'b1 || req_A !== 19'h60000 || req_rnw !== 1'b1
        || req_dsn !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_req: br %b A %h rnw %b dsn %b", sub_br, req_A,
               req_rnw, req_dsn);
    end
    sub_ok = 1; sub_din = 16'h1234;
    sb.push_back('{din: 16'h1234, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat) begin
      tests_failed++;
      $display("FAIL read_lat: got %0d want %0d", n, e.lat);
    end
    tests_run++;
    if (main_din !== e.din || timeout_err !== e.err) begin
      tests_failed++;
      $display("FAIL read_data: got %h want %h", main_din, e.din);
    end
    tests_run++;
    if (sub_br !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_br_drop: got %b want 0", sub_br);
    end
    finish_txn;
    tests_run++;
    if (main_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_ok_drop: got %b want 0", main_ok);
    end
  endtask

  task automatic test_write;
    int n; bit got; exp_t e;
    tick;
    start(19'h00abc, 2'b01, 1'b0, 16'hbeef);
    sub_din = 16'hdead;
    tick;
    for (int i = 0; i < 7; i++) tick;
    tests_run++;
    if (sub_br !== 1'b1 || req_dout !== 16'hbeef || req_dsn !== 2'b01
        || req_rnw !== 1'b0 || main_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_hold: br %b dout %h dsn %b ok %b want 1 beef 01 0",
               sub_br, req_dout, req_dsn, main_ok);
    end
    sub_ok = 1;
    sb.push_back('{din: 16'h1234, lat: 8, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || 7 + n !== e.lat || main_din !== e.din) begin
      tests_failed++;
      $display("FAIL write_done: lat %0d din %h want %0d %h", 7 + n,
               main_din, e.lat, e.din);
    end
    finish_txn;
  endtask

  task automatic test_stale_ok;
    int n; bit got; exp_t e;
    sub_ok = 1; sub_din = 16'h0f0f;
    tick; tick;
    start(19'h40001, 2'b10, 1'b1, 16'h0);
    tick;
    sb.push_back('{din: 16'h0f0f, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat || main_din !== e.din) begin
      tests_failed++;
      $display("FAIL stale_ok: lat %0d din %h want %0d %h", n, main_din,
               e.lat, e.din);
    end
    finish_txn;
  endtask

  task automatic test_timeout;
    int n; bit got; exp_t e;
    tick;
    start(19'h7ffff, 2'b00, 1'b1, 16'h0);
    tick;
    sb.push_back('{din: 16'hffff, lat: TIMEOUT, err: 1'b1});
    wait_ok(TIMEOUT + 10, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat) begin
      tests_failed++;
      $display("FAIL tout_lat: got %0d want %0d", n, e.lat);
    end
    tests_run++;
    if (main_din !== e.din || timeout_err !== e.err || sub_br !== 1'b0) begin
      tests_failed++;
      $display("FAIL tout_vals: din %h err %b br %b want ffff 1 0",
               main_din, timeout_err, sub_br);
    end
    finish_txn;
    tick;
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b want 1", timeout_err);
    end
    clr_err = 1;
    tick;
    clr_err = 0;
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_abort;
    int n; bit got; bit seen; exp_t e;
    seen = 0;
    start(19'h00010, 2'b10, 1'b0, 16'h1111);
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (main_ok !== 1'b0) seen = 1;
    end
    cs = 0;
    tick;
    tests_run++;
    if (sub_br !== 1'b0 || req_dsn !== 2'b11) begin
      tests_failed++;
      $display("FAIL abort_rel: br %b dsn %b want 0 11", sub_br, req_dsn);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      if (main_ok !== 1'b0 || sub_br !== 1'b0) seen = 1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL abort_quiet: got activity 1 want 0");
    end
    start(19'h00020, 2'b00, 1'b1, 16'h0);
    tick;
    sub_ok = 1; sub_din = 16'h2222;
    sb.push_back('{din: 16'h2222, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat || main_din !== e.din || timeout_err !== e.err) begin
      tests_failed++;
      $display("FAIL after_abort: lat %0d din %h want %0d %h", n, main_din,
               e.lat, e.din);
    end
    finish_txn;
  endtask

  task automatic test_rst_mid;
    tick;
    start(19'h03333, 2'b00, 1'b1, 16'h0);
    tick; tick; tick;
    rst = 1; cs = 0;
    tick;
    tests_run++;
    if (out_vec() !== RST_VEC) begin
      tests_failed++;
      $display("FAIL rst_mid: got %h want %h", out_vec(), RST_VEC);
    end
    rst = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    int n; bit got; int gap; exp_t e;
    sub_ok = 1; sub_din = 16'h3333;
    start(19'h05555, 2'b00, 1'b1, 16'h0);
    tick;
    sb.push_back('{din: 16'h3333, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat || main_din !== e.din) begin
      tests_failed++;
      $display("FAIL b2b_first: lat %0d din %h want %0d %h", n, main_din,
               e.lat, e.din);
    end
    gap = (sub_br === 1'b0) ? 1 : 0;
    cs = 0;
    tick;
    if (sub_br === 1'b0) gap++;
    start(19'h06666, 2'b00, 1'b1, 16'h0);
    sub_din = 16'h4444;
    tick;
    tests_run++;
    if (gap < 1 || sub_br !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap: gap %0d br %b want >=1 1", gap, sub_br);
    end
    sb.push_back('{din: 16'h4444, lat: IMM, err: 1'b0});
    wait_ok(20, n, got);
    e = sb.pop_front();
    tests_run++;
    if (!got || n !== e.lat || main_din !== e.din) begin
      tests_failed++;
      $display("FAIL b2b_second: lat %0d din %h want %0d %h", n, main_din,
               e.lat, e.din);
    end
    finish_txn;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_stale_ok;
    test_timeout;
    test_abort;
    test_rst_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
